// File: rtl/rx_pkg.sv
// -----------------------------------------------------------------------------
// rx_pkg
// Shared definitions for the oversampling serial receiver (rx_sipo):
//   - receiver state enumeration
//   - ParityType encodings
//   - bit positions inside the captured 11-bit frame word
//   - small helper functions (parity-enable decode, 2-of-3 majority)
// No ports (package).
// -----------------------------------------------------------------------------
package rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } rx_state_e;

    // ParityType encodings; both "none" codes behave identically.
    localparam logic [1:0] PAR_NONE0 = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE3 = 2'b11;

    // Layout of the captured frame word.
    localparam int FRAME_W     = 11;
    localparam int IDX_START   = 0;
    localparam int IDX_DATA_LO = 1;
    localparam int IDX_DATA_HI = 8;
    localparam int IDX_PARITY  = 9;
    localparam int IDX_STOP    = 10;

    // Value the frame word takes out of reset (looks like an idle line).
    localparam logic [FRAME_W-1:0] FRAME_IDLE = '1;

    function automatic logic parity_en(input logic [1:0] ptype);
        return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// -----------------------------------------------------------------------------
// rx_sync
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to
// 1 so that a reset never looks like a falling edge (idle line is high).
// Ports:
//   clk_i    in  system clock
//   rst_i    in  asynchronous active-high reset
//   async_i  in  asynchronous input (serial line)
//   sync_o   out synchronized copy of async_i, two clocks of latency
// -----------------------------------------------------------------------------
module rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse the two stages.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/rx_sipo.sv
// -----------------------------------------------------------------------------
// rx_sipo
// Oversampling serial-in / parallel-out receiver. Frames are start bit,
// 7 or 8 data bits LSB-first, optional parity bit (stored raw), stop bit.
//
// Parameters:
//   OVERSAMPLE   BaudTick pulses per bit period (even, >= 8)
// Ports:
//   Clock         in   system clock, rising edge
//   Reset         in   asynchronous active-high reset
//   BaudTick      in   one-clock enable at OVERSAMPLE x baud
//   RxIn          in   asynchronous serial line, idle high
//   DataLength    in   1 = 8 data bits, 0 = 7 data bits
//   ParityType    in   00/11 none, 01 odd, 10 even
//   DataParl      out  [0] start, [8:1] data, [9] parity, [10] stop
//   RecievedFlag  out  one-clock pulse while DataParl holds a new frame
//   Active        out  high while a frame is in progress
//   FrameErr      out  stop bit sampled low; held until the next frame
//
// Build option:
//   RX_MAJORITY_VOTE_EN  defined: each bit is the 2-of-3 majority of ticks
//                        OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 of its
//                        period; undefined: single sample at OVERSAMPLE/2.
//                        Decision timing is the same in both builds.
//
// Timing model: every tick the synchronized line is captured into samp_q and
// the previous capture moves to prev_q. A falling edge is seen one tick after
// the first low sample, so counting OVERSAMPLE/2 ticks from there lands the
// decision one tick past the bit centre. At that point samp_q holds the
// centre sample, prev_q the one before it and the live line the one after.
// -----------------------------------------------------------------------------
module rx_sipo
    import rx_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                BaudTick,
    input  logic                RxIn,
    input  logic                DataLength,
    input  logic [1:0]          ParityType,
    output logic [FRAME_W-1:0]  DataParl,
    output logic                RecievedFlag,
    output logic                Active,
    output logic                FrameErr
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);

    logic rx_s;

    rx_sync u_sync (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .async_i (RxIn),
        .sync_o  (rx_s)
    );

    rx_state_e            state_q,     state_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic [2:0]           bit_idx_q,   bit_idx_d;
    logic [7:0]           shift_q,     shift_d;
    logic                 par_q,       par_d;
    logic                 len8_q,      len8_d;
    logic [1:0]           par_type_q,  par_type_d;
    logic                 samp_q,      samp_d;
    logic                 prev_q,      prev_d;
    logic [FRAME_W-1:0]   data_parl_q, data_parl_d;
    logic                 frame_err_q, frame_err_d;

    logic                 bit_val;
    logic [2:0]           bit_last;
    logic [7:0]           data_w;

    // Value of the bit being decided on the current tick.
    always_comb begin
`ifdef RX_MAJORITY_VOTE_EN
        bit_val = maj3(prev_q, samp_q, rx_s);
`else
        bit_val = samp_q;
`endif
    end

    assign bit_last = len8_q ? 3'd7 : 3'd6;
    // With 7 data bits only seven shifts happen, leaving the data in [7:1].
    assign data_w   = len8_q ? shift_q : {1'b0, shift_q[7:1]};

    // NOTE: every variable gets a default at the top of the block, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        len8_d      = len8_q;
        par_type_d  = par_type_q;
        samp_d      = samp_q;
        prev_d      = prev_q;
        data_parl_d = data_parl_q;
        frame_err_d = frame_err_q;

        if (BaudTick) begin
            samp_d = rx_s;
            prev_d = samp_q;
        end

        case (state_q)
            ST_IDLE: begin
                // Edge detection on tick samples: a held-low line never
                // re-arms because prev_q stays low until the line rises.
                if (BaudTick && !samp_q && prev_q) begin
                    state_d    = ST_START;
                    cnt_d      = '0;
                    len8_d     = DataLength;
                    par_type_d = ParityType;
                end
            end

            ST_START: begin
                if (BaudTick) begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = bit_val ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (BaudTick) begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {bit_val, shift_q[7:1]};
                        if (bit_idx_q == bit_last) begin
                            state_d = parity_en(par_type_q) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                if (BaudTick) begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        par_d   = bit_val;
                        state_d = ST_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_STOP: begin
                if (BaudTick) begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d = '0;
                        // Loaded on entry to DONE so the new word is visible
                        // during the single flag cycle.
                        data_parl_d[IDX_START]               = 1'b0;
                        data_parl_d[IDX_DATA_HI:IDX_DATA_LO] = data_w;
                        data_parl_d[IDX_PARITY]              = parity_en(par_type_q) ? par_q : 1'b0;
                        data_parl_d[IDX_STOP]                = bit_val;
                        frame_err_d = ~bit_val;
                        state_d     = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            len8_q      <= 1'b1;
            par_type_q  <= PAR_NONE0;
            samp_q      <= 1'b1;
            prev_q      <= 1'b1;
            data_parl_q <= FRAME_IDLE;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            len8_q      <= len8_d;
            par_type_q  <= par_type_d;
            samp_q      <= samp_d;
            prev_q      <= prev_d;
            data_parl_q <= data_parl_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign DataParl     = data_parl_q;
    assign FrameErr     = frame_err_q;
    assign RecievedFlag = (state_q == ST_DONE);
    assign Active       = (state_q == ST_START) || (state_q == ST_DATA) ||
                          (state_q == ST_PARITY) || (state_q == ST_STOP);

endmodule
